// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states, owner encoding and access size codes.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and shared memory-port signals around the arbiter.
interface mem_port_arbiter_if;

  // Handshakes: a requester raises *_req with its fields and holds them stable until
  // the cycle its *_gnt is high; mem_req likewise holds the command until mem_ack.
  // *_rvalid is a single-cycle strobe with the data valid in that same cycle.
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [63:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [2:0]  ls_size;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        protocol_err;

  modport master (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_size,
    input  mem_ack, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output protocol_err
  );

  modport slave (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_size,
    output mem_ack, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  protocol_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port, one transaction at a time,
// with load/store priority bounded by a fetch starvation counter.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mem_port_arbiter_if.master            bus,
  output arb_state_t                    dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0] dbg_fetch_wait
);

  localparam int FW_W = $clog2(MAX_WAIT + 1);
  localparam logic [FW_W-1:0] FW_MAX = FW_W'(MAX_WAIT);

  arb_state_t      state_q, state_d;
  arb_owner_t      owner_q, owner_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [2:0]      mem_size_q, mem_size_d;
  logic [63:0]     mem_addr_q, mem_addr_d;
  logic [63:0]     mem_wdata_q, mem_wdata_d;
  logic [FW_W-1:0] fetch_wait_q, fetch_wait_d;
  logic            protocol_err_q, protocol_err_d;
  logic            fetch_win;
  logic            ack_fire;
  logic            resp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      owner_q        <= OWN_IF;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_size_q     <= 3'd0;
      mem_addr_q     <= 64'd0;
      mem_wdata_q    <= 64'd0;
      fetch_wait_q   <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_size_q     <= mem_size_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      fetch_wait_q   <= fetch_wait_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_size_d     = mem_size_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    fetch_wait_d   = fetch_wait_q;
    fetch_win      = 1'b0;
    // A response can only be legal while a read is waiting for it.
    protocol_err_d = protocol_err_q | (bus.mem_rvalid && (state_q != WAIT_RESP));

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.ls_req) begin
          fetch_win = bus.if_req && (!bus.ls_req || (fetch_wait_q == FW_MAX));
          state_d   = WAIT_ACK;
          mem_req_d = 1'b1;
          if (fetch_win) begin
            owner_d      = OWN_IF;
            mem_we_d     = 1'b0;
            mem_size_d   = SIZE_W;
            mem_addr_d   = bus.if_addr;
            mem_wdata_d  = 64'd0;
            fetch_wait_d = '0;
          end else begin
            owner_d     = OWN_LS;
            mem_we_d    = bus.ls_we;
            mem_size_d  = bus.ls_size;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
            if (bus.if_req && (fetch_wait_q != FW_MAX)) begin
              fetch_wait_d = fetch_wait_q + FW_W'(1);
            end
          end
        end
      end
      WAIT_ACK: begin
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_fire  = (state_q == WAIT_ACK) && mem_req_q && bus.mem_ack;
  assign resp_fire = (state_q == WAIT_RESP) && bus.mem_rvalid;

  assign bus.if_gnt    = ack_fire && (owner_q == OWN_IF);
  assign bus.ls_gnt    = ack_fire && (owner_q == OWN_LS);
  assign bus.if_rvalid = resp_fire && (owner_q == OWN_IF);
  assign bus.ls_rvalid = resp_fire && (owner_q == OWN_LS);

  // Fetches are word sized; the latched address picks the word lane.
  assign bus.if_rdata = mem_addr_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
  assign bus.ls_rdata = bus.mem_rdata;

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_size     = mem_size_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.protocol_err = protocol_err_q;

  assign dbg_state      = state_q;
  assign dbg_fetch_wait = fetch_wait_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single transactions plus
// hand-written sequences for contention, starvation, ack stall and reset mid-transaction.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;
  logic [2:0] dbg_fetch_wait;
  int         n_checks;
  int         n_fail;
  int         if_gnt_cnt;
  int         ls_gnt_cnt;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_fetch_wait (dbg_fetch_wait)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (bus.if_gnt) if_gnt_cnt++;
    if (bus.ls_gnt) ls_gnt_cnt++;
  end

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    int          ack_dly;
    logic [63:0] rdata;
    logic        exp_we;
    logic [2:0]  exp_size;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_mem_req(input string nm, input int exp_lat);
    int k;
    k = 0;
    sample();
    while (!bus.mem_req && k < 20) begin
      sample();
      k++;
    end
    chk(nm, 64'(k), 64'(exp_lat));
  endtask

  // Ack now, then return read data; exp_gnt is {if, ls}.
  task automatic serve(input string nm, input logic [1:0] exp_gnt,
                       input logic [63:0] rdata, input logic [63:0] exp_rd);
    step();
    bus.mem_ack = 1'b1;
    sample();
    chk({nm, "_gnt"}, 64'({bus.if_gnt, bus.ls_gnt}), 64'(exp_gnt));
    step();
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rdata;
    sample();
    chk({nm, "_rvalid"}, 64'({bus.if_rvalid, bus.ls_rvalid}), 64'(exp_gnt));
    chk({nm, "_rdata"}, exp_gnt[1] ? 64'(bus.if_rdata) : bus.ls_rdata, exp_rd);
    step();
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        exp_if;
    n_checks   = 0;
    n_fail     = 0;
    if_gnt_cnt = 0;
    ls_gnt_cnt = 0;

    vecs[0] = '{1'b0, 1'b0, 64'h1004, 64'h0,    3'd0, 2, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, 3'd2, 64'hAAAA_BBBB};
    vecs[1] = '{1'b0, 1'b0, 64'h1008, 64'h0,    3'd0, 0, 64'h1111_2222_3333_4444, 1'b0, 3'd2, 64'h3333_4444};
    vecs[2] = '{1'b1, 1'b0, 64'h2000, 64'h0,    3'd3, 1, 64'hDEAD_BEEF_0123_4567, 1'b0, 3'd3, 64'hDEAD_BEEF_0123_4567};
    vecs[3] = '{1'b1, 1'b1, 64'h3000, 64'h1234, 3'd3, 0, 64'h0,                   1'b1, 3'd3, 64'h0};
    vecs[4] = '{1'b1, 1'b0, 64'h2004, 64'h0,    3'd2, 3, 64'h0F0F_1E1E_2D2D_3C3C, 1'b0, 3'd2, 64'h0F0F_1E1E_2D2D_3C3C};
    vecs[5] = '{1'b1, 1'b1, 64'h3001, 64'hAB,   3'd0, 1, 64'h0,                   1'b1, 3'd0, 64'h0};

    rst_n          = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 64'd0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = 64'd0;
    bus.ls_wdata   = 64'd0;
    bus.ls_size    = 3'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 64'd0;

    repeat (2) sample();
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_mem_size", 64'(bus.mem_size), 64'd0);
    chk("rst_fetch_wait", 64'(dbg_fetch_wait), 64'd0);
    chk("rst_protocol_err", 64'(bus.protocol_err), 64'd0);
    chk("rst_gnt_rvalid", 64'({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid}), 64'd0);
    step();
    rst_n = 1'b1;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      step();
      if (vecs[i].is_ls) begin
        bus.ls_req   = 1'b1;
        bus.ls_we    = vecs[i].we;
        bus.ls_addr  = vecs[i].addr;
        bus.ls_wdata = vecs[i].wdata;
        bus.ls_size  = vecs[i].size;
      end else begin
        bus.if_req  = 1'b1;
        bus.if_addr = vecs[i].addr;
      end
      wait_mem_req($sformatf("v%0d_lat", i), 1);
      chk($sformatf("v%0d_mem_we", i), 64'(bus.mem_we), 64'(vecs[i].exp_we));
      chk($sformatf("v%0d_mem_size", i), 64'(bus.mem_size), 64'(vecs[i].exp_size));
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].addr);
      if (vecs[i].is_ls) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].wdata);
      for (int d = 0; d < vecs[i].ack_dly; d++) begin
        step();
        sample();
        chk($sformatf("v%0d_no_gnt%0d", i, d), 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
      end
      step();
      bus.mem_ack = 1'b1;
      sample();
      chk($sformatf("v%0d_gnt", i), 64'({bus.if_gnt, bus.ls_gnt}),
          vecs[i].is_ls ? 64'd1 : 64'd2);
      step();
      bus.mem_ack = 1'b0;
      bus.if_req  = 1'b0;
      bus.ls_req  = 1'b0;
      if (!vecs[i].we) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = vecs[i].rdata;
        sample();
        chk($sformatf("v%0d_rvalid", i), 64'({bus.if_rvalid, bus.ls_rvalid}),
            vecs[i].is_ls ? 64'd1 : 64'd2);
        chk($sformatf("v%0d_rdata", i),
            vecs[i].is_ls ? bus.ls_rdata : 64'(bus.if_rdata), vecs[i].exp_rdata);
        step();
        bus.mem_rvalid = 1'b0;
        sample();
      end else begin
        sample();
        chk($sformatf("v%0d_no_rvalid", i), 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
      end
      chk($sformatf("v%0d_idle", i), 64'(dbg_state), 64'(IDLE));
      if (i == 0) chk("v0_fetch_grant_count", 64'(if_gnt_cnt), 64'd1);
    end
    chk("tbl_if_gnt_count", 64'(if_gnt_cnt), 64'd2);
    chk("tbl_ls_gnt_count", 64'(ls_gnt_cnt), 64'd4);
    chk("tbl_fetch_wait", 64'(dbg_fetch_wait), 64'd0);

    // simultaneous requests: load first, fetch after one idle cycle
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1000;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h2000;
    bus.ls_size = 3'd3;
    wait_mem_req("sim_ls_lat", 1);
    chk("sim_ls_addr", bus.mem_addr, 64'h2000);
    chk("sim_fetch_wait1", 64'(dbg_fetch_wait), 64'd1);
    serve("sim_ls", 2'b01, 64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708);
    bus.ls_req = 1'b0;
    wait_mem_req("sim_if_lat", 1);
    chk("sim_if_addr", bus.mem_addr, 64'h1000);
    chk("sim_if_size", 64'(bus.mem_size), 64'(SIZE_W));
    chk("sim_fetch_wait0", 64'(dbg_fetch_wait), 64'd0);
    serve("sim_if", 2'b10, 64'h9999_8888_7777_6666, 64'h7777_6666);
    bus.if_req = 1'b0;

    // starvation: fetch forced through on the fifth arbitration
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h4000;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h5000;
    bus.ls_size = 3'd3;
    for (int i = 1; i <= 6; i++) begin
      exp_if = (i == 5);
      wait_mem_req($sformatf("stv%0d_lat", i), 1);
      chk($sformatf("stv%0d_addr", i), bus.mem_addr, exp_if ? 64'h4000 : 64'h5000);
      chk($sformatf("stv%0d_fetch_wait", i), 64'(dbg_fetch_wait), (i <= 4) ? 64'(i) : 64'd0);
      rd = {32'hCAFE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
      serve($sformatf("stv%0d", i), exp_if ? 2'b10 : 2'b01, rd,
            exp_if ? {32'd0, rd[31:0]} : rd);
      if (i == 5) bus.if_req = 1'b0;
    end
    bus.ls_req = 1'b0;

    // ack stall: command must hold steady with no grant
    step();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 64'h6000;
    bus.ls_wdata = 64'h55AA;
    bus.ls_size  = 3'd3;
    wait_mem_req("stall_lat", 1);
    for (int k = 0; k < 10; k++) begin
      step();
      sample();
      chk($sformatf("stall%0d_req", k), 64'(bus.mem_req), 64'd1);
      chk($sformatf("stall%0d_cmd", k), {bus.mem_addr[59:0], bus.mem_we, bus.mem_size},
          {60'h6000, 1'b1, 3'd3});
      chk($sformatf("stall%0d_wdata", k), bus.mem_wdata, 64'h55AA);
      chk($sformatf("stall%0d_no_gnt", k), 64'({bus.if_gnt, bus.ls_gnt}), 64'd0);
    end
    step();
    bus.mem_ack = 1'b1;
    sample();
    chk("stall_gnt", 64'({bus.if_gnt, bus.ls_gnt}), 64'd1);
    step();
    bus.mem_ack = 1'b0;
    bus.ls_req  = 1'b0;
    sample();
    chk("stall_idle", 64'(dbg_state), 64'(IDLE));
    chk("stall_req_low", 64'(bus.mem_req), 64'd0);
    chk("pre_rst_protocol_err", 64'(bus.protocol_err), 64'd0);

    // reset while waiting for a read response, then a stray response
    step();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h7004;
    wait_mem_req("rst_mid_lat", 1);
    step();
    bus.mem_ack = 1'b1;
    sample();
    chk("rst_mid_gnt", 64'({bus.if_gnt, bus.ls_gnt}), 64'd2);
    step();
    bus.mem_ack = 1'b0;
    bus.if_req  = 1'b0;
    sample();
    chk("rst_mid_wait_resp", 64'(dbg_state), 64'(WAIT_RESP));
    step();
    rst_n = 1'b0;
    sample();
    chk("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    chk("rst_mid_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mid_mem_addr", bus.mem_addr, 64'd0);
    step();
    rst_n = 1'b1;
    sample();
    chk("rst_mid_err_clear", 64'(bus.protocol_err), 64'd0);
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h1357_2468_ACE0_BDF1;
    sample();
    chk("late_no_rvalid", 64'({bus.if_rvalid, bus.ls_rvalid}), 64'd0);
    step();
    bus.mem_rvalid = 1'b0;
    sample();
    chk("late_protocol_err", 64'(bus.protocol_err), 64'd1);
    chk("late_mem_req", 64'(bus.mem_req), 64'd0);
    chk("late_state", 64'(dbg_state), 64'(IDLE));

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter SHALL be declared: MAX_WAIT, default 4, consecutive fetch losses before fetch is forced to win.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 if_req  input  1  fetch request; held with if_addr until if_gnt.
REQ-005 if_addr  input  64  fetch byte address, 4-byte aligned.
REQ-006 if_gnt  output  1  fetch request accepted by memory.
REQ-007 if_rvalid / if_rdata  output  1 / 32  fetch response valid, instruction word.
REQ-008 ls_req, ls_we  input  1, 1  load/store request and write flag; held with fields until ls_gnt.
REQ-009 ls_addr, ls_wdata  input  64, 64  load/store address and store data.
REQ-010 ls_size  input  3  access size code, passed through unchanged.
REQ-011 ls_gnt  output  1  load/store request accepted by memory.
REQ-012 ls_rvalid / ls_rdata  output  1 / 64  load response valid and data.
REQ-013 mem_req, mem_we, mem_size, mem_addr, mem_wdata  output  1, 1, 3, 64, 64  shared memory port command.
REQ-014 mem_ack  input  1  memory accepts the command while mem_req=1.
REQ-015 mem_rvalid / mem_rdata  input  1 / 64  read response.
REQ-016 protocol_err  output  1  sticky flag for unexpected mem_rvalid.

Function
REQ-017 FSM SHALL have states IDLE, WAIT_ACK and WAIT_RESP.
REQ-018 In IDLE with any request, the arbiter SHALL latch the winner into the mem_* registers and enter WAIT_ACK; mem_req SHALL rise the next cycle, one cycle of latency.
REQ-019 Priority SHALL be: ls wins over if, except that fetch wins when fetch_wait==MAX_WAIT.
REQ-020 fetch_wait SHALL increment when ls wins while if_req=1, saturate at MAX_WAIT, and clear when fetch is granted.
REQ-021 A fetch SHALL drive mem_we=0 and mem_size=3'b010, with mem_addr = if_addr.
REQ-022 In WAIT_ACK, mem_req and the command SHALL hold stable until mem_ack.
REQ-023 The owner's gnt SHALL pulse for exactly one cycle, in the same cycle as mem_req & mem_ack (combinational from the owner register).
REQ-024 After ack, a write SHALL return to IDLE with no response; a read SHALL enter WAIT_RESP.
REQ-025 In WAIT_RESP, mem_rvalid SHALL produce a one-cycle rvalid to the owner only, then return to IDLE.
REQ-026 if_rdata SHALL be mem_rdata[63:32] when the latched addr[2]=1, else mem_rdata[31:0].
REQ-027 ls_rdata SHALL be mem_rdata unmodified.
REQ-028 rvalid outputs SHALL be combinational with mem_rvalid in WAIT_RESP, giving zero added response latency.
REQ-029 Requests SHALL NOT be arbitrated in WAIT_ACK or WAIT_RESP; at most one transaction SHALL be outstanding.
REQ-030 A new arbitration SHALL occur in the IDLE cycle immediately after completion, so back-to-back transactions have one idle cycle.
REQ-031 mem_rvalid outside WAIT_RESP SHALL be ignored, SHALL NOT produce rvalid, and SHALL set protocol_err.
REQ-032 A requester dropping req before gnt is illegal; behaviour in that case is undefined.

Reset
REQ-033 While rst_n=0, the following SHALL hold: state=IDLE, mem_req=0, mem_we=0, mem_addr/mem_wdata/mem_size=0, fetch_wait=0, protocol_err=0, and all gnt/rvalid outputs=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction; a late mem_rvalid after reset SHALL set protocol_err.

Structure
REQ-035 The package riscv_pkg SHALL hold arb_state_t (IDLE/WAIT_ACK/WAIT_RESP), arb_owner_t (OWN_IF/OWN_LS) and the size codes (SIZE_B/H/W/D = 0/1/2/3).
REQ-036 The block SHALL be implemented as a single module with no sub-module; the saturating fetch_wait counter SHALL be inline.

Verification
REQ-037 Single fetch: if_req, if_addr=0x1004, ack after 2 cycles, rdata=0xAAAA_BBBB_CCCC_DDDD -> if_rvalid with if_rdata=0xAAAABBBB; fetch counts as 1 grant.
REQ-038 Simultaneous: if_req and ls_req (load 0x2000) both held -> ls granted first, fetch granted second; the fetch mem_req appears 1 cycle after the load rvalid.
REQ-039 Starvation: ls_req held continuously with if_req, MAX_WAIT=4 -> fetch granted on the 5th arbitration.
REQ-040 Store: ls_we=1, addr=0x3000, wdata=0x1234, size=3 -> mem_* match the request, ls_gnt pulses at ack, no ls_rvalid, FSM returns to IDLE.
REQ-041 Reset asserted in WAIT_RESP, then mem_rvalid after release -> no rvalid output, protocol_err=1, mem_req=0.
REQ-042 Ack stall: mem_ack held low for 10 cycles -> mem_* stable across those cycles and no gnt until ack.
